// File: rtl/fp_add_arb_if.sv
// Requester and adder-side bus for fp_add_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding logic
// (requesters plus the adder pipeline).
interface fp_add_arb_if #(
  parameter int W     = 32,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0][W-1:0] req_a;
  logic [N_REQ-1:0][W-1:0] req_b;
  logic [N_REQ-1:0]        req_sub;
  logic                    add_valid;
  logic [W-1:0]            add_a;
  logic [W-1:0]            add_b;
  logic                    add_sub;
  logic                    add_res_valid;
  logic [W-1:0]            add_res;
  logic [N_REQ-1:0]        rsp_valid;
  logic [W-1:0]            rsp_data;
  logic                    err;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_res_valid, add_res,
    output req_ready, add_valid, add_a, add_b, add_sub, rsp_valid, rsp_data, err
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, add_res_valid, add_res,
    input  req_ready, add_valid, add_a, add_b, add_sub, rsp_valid, rsp_data, err
  );
endinterface

// File: rtl/fp_add_arb.sv
// Round-robin arbiter sharing one fixed-latency FP add/sub pipeline among N_REQ requesters.
// Issues at most one op per cycle, tracks each op's owner in a tag pipe that lines up with
// the adder result, and caps in-flight ops per requester at MAX_OUT.

// Per-requester in-flight counter; saturates at both ends.
module fp_add_arb_cnt #(
  parameter int CW      = 2,
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: issue and retire in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q < CW'(MAX_OUT)) cnt_d = cnt_q + 1'b1;
    else if (dec && !inc && cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign full = (cnt_q >= CW'(MAX_OUT));
endmodule

module fp_add_arb #(
  parameter int SIG_BITS = 23,
  parameter int EXP_BITS = 8,
  parameter int N_REQ    = 4,
  parameter int LATENCY  = 4,
  parameter int MAX_OUT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  fp_add_arb_if.slave  bus
);
  localparam int W  = 1 + EXP_BITS + SIG_BITS;
  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [TW-1:0]          ptr_q, ptr_d;
  logic [N_REQ-1:0]       full, elig, gnt, dec;
  logic [TW-1:0]          gnt_idx;
  logic                   gnt_any;

  logic                   add_valid_q, add_valid_d;
  logic [W-1:0]           add_a_q, add_a_d, add_b_q, add_b_d;
  logic                   add_sub_q, add_sub_d;

  // Tag pipe: stage k holds the op issued k+1 cycles ago; stage LATENCY meets add_res_valid.
  logic [LATENCY:0]       vld_pipe_q, vld_pipe_d;
  logic [LATENCY:0][TW-1:0] tag_pipe_q, tag_pipe_d;
  logic                   tail_vld;
  logic [TW-1:0]          tail_tag;

  logic [N_REQ-1:0]       rsp_valid;
  logic [W-1:0]           rsp_data;
  logic                   err_q, err_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    fp_add_arb_cnt #(.CW(CW), .MAX_OUT(MAX_OUT)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (gnt[i]),
      .dec  (dec[i]),
      .full (full[i])
    );
  end

  // Round-robin pick: first eligible requester at or after ptr, wrapping; nothing during reset.
  always_comb begin
    int idx;
    idx     = 0;
    elig    = bus.req_valid & ~full;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && elig[idx] && !rst) begin
        gnt_any = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt;

  // Pointer moves just past the winner; issue registers load the winner's operands.
  always_comb begin
    ptr_d       = ptr_q;
    add_valid_d = gnt_any;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_sub_d   = add_sub_q;
    if (gnt_any) begin
      ptr_d     = (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      add_a_d   = bus.req_a[gnt_idx];
      add_b_d   = bus.req_b[gnt_idx];
      add_sub_d = bus.req_sub[gnt_idx];
    end
  end

  // Tag pipe shift; a new entry enters on every transfer.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[LATENCY-1:0], gnt_any};
    tag_pipe_d = {tag_pipe_q[LATENCY-1:0], gnt_idx};
  end

  assign tail_vld = vld_pipe_q[LATENCY];
  assign tail_tag = tag_pipe_q[LATENCY];

  // Route the result to the tail owner; retire the tail even if the adder result is missing.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    dec       = '0;
    if (tail_vld) dec[tail_tag] = 1'b1;
    if (tail_vld && bus.add_res_valid && !rst) begin
      rsp_valid[tail_tag] = 1'b1;
      rsp_data            = bus.add_res;
    end
    err_d = err_q | (tail_vld != bus.add_res_valid);
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.add_valid = add_valid_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_sub   = add_sub_q;
  assign bus.err       = err_q;

  // State registers; reset flushes the pointer, issue stage, tag pipe and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_sub_q   <= 1'b0;
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_sub_q   <= add_sub_d;
      vld_pipe_q  <= vld_pipe_d;
      tag_pipe_q  <= tag_pipe_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_fp_add_arb.sv
// Randomized scoreboard bench for fp_add_arb with a behavioural FP adder model.
module tb_fp_add_arb;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int LAT  = 4;
  localparam int MAXO = 2;

  typedef struct {
    int          req;
    logic [31:0] data;
    int          ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic inj;
  always #5 clk = ~clk;

  fp_add_arb_if #(.W(W), .N_REQ(N)) bus ();

  fp_add_arb #(.SIG_BITS(23), .EXP_BITS(8), .N_REQ(N), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ptr_m;
  int   out_m [N];
  logic add_exp;
  logic err_exp;
  logic [N-1:0] xfer_last;
  int   last_xfer_cyc;
  int   last_rsp_cyc;
  logic [31:0] last_rsp_data;
  logic [N-1:0] last_rsp_vec;
  exp_t exp_q[$];
  exp_t fl_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single-precision value to real and back, via plain arithmetic on the fields.
  function automatic real from_single(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_single(input real r);
    logic [63:0] d;
    logic [30:0] em;
    logic [28:0] rem;
    int          e;
    if (r == 0.0) return 32'h0;
    d   = $realtobits(r);
    e   = int'(d[62:52]) - 1023 + 127;
    em  = {e[7:0], d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && em[0])) em = em + 1'b1;
    return {d[63], em};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real s;
    s = sub ? from_single(a) - from_single(b) : from_single(a) + from_single(b);
    return to_single(s);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(134, 120));
    return {1'($urandom_range(1)), e, 23'($urandom)};
  endfunction

  // Adder model: fixed LAT-cycle pipeline, flushed by reset, plus an injection hook.
  logic [LAT-1:0] am_v;
  logic [31:0]    am_d [LAT];
  always @(posedge clk) begin
    if (rst) am_v <= '0;
    else begin
      for (int k = LAT - 1; k > 0; k--) begin
        am_v[k] <= am_v[k-1];
        am_d[k] <= am_d[k-1];
      end
      am_v[0] <= bus.add_valid;
      am_d[0] <= fp_add(bus.add_a, bus.add_b, bus.add_sub);
    end
  end
  assign bus.add_res_valid = am_v[LAT-1] | inj;
  assign bus.add_res       = am_d[LAT-1];

  // Monitor: pops the scoreboard whenever a response appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("err", bus.err, err_exp);
      if (rst) chk("rsp_in_rst", bus.rsp_valid, 0);
      else if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_valid", bus.rsp_valid, 64'(1) << e.req);
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_cycle", cyc, e.ret);
          last_rsp_cyc  = cyc;
          last_rsp_data = bus.rsp_data;
          last_rsp_vec  = bus.rsp_valid;
        end
      end else begin
        chk("rsp_data_idle", bus.rsp_data, 0);
        if (exp_q.size() > 0 && exp_q[0].ret <= cyc) begin
          chk("rsp_missing", bus.rsp_valid, 64'(1) << exp_q[0].req);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle: check grant against the round-robin model, record transfers, advance.
  task automatic step();
    int   g;
    int   idx;
    logic rst_s;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    g = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && bus.req_valid[idx] && out_m[idx] < MAXO) g = idx;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("add_valid", bus.add_valid, add_exp);
    xfer_last = '0;
    if (rst) begin
      ptr_m = 0;
      for (int i = 0; i < N; i++) out_m[i] = 0;
      exp_q.delete();
      fl_q.delete();
    end else begin
      while (fl_q.size() > 0 && fl_q[0].ret == cyc) begin
        out_m[fl_q[0].req]--;
        void'(fl_q.pop_front());
      end
      if (g >= 0) begin
        e.req  = g;
        e.data = fp_add(bus.req_a[g], bus.req_b[g], bus.req_sub[g]);
        e.ret  = cyc + 1 + LAT;
        exp_q.push_back(e);
        fl_q.push_back(e);
        out_m[g]++;
        ptr_m = (g + 1) % N;
        xfer_last[g] = 1'b1;
        last_xfer_cyc = cyc;
      end
    end
    add_exp = (g >= 0);
    rst_s   = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) err_exp = 1'b0;
  endtask

  task automatic new_op(input int i, input int dens);
    bus.req_valid[i] = ($urandom_range(99) < dens);
    bus.req_a[i]     = rand_fp();
    bus.req_b[i]     = rand_fp();
    bus.req_sub[i]   = 1'($urandom_range(1));
  endtask

  task automatic run(input int n, input int dens, input logic [N-1:0] mask);
    for (int c = 0; c < n; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if (!mask[i]) bus.req_valid[i] = 1'b0;
        else if (xfer_last[i] || !bus.req_valid[i]) new_op(i, dens);
    end
  endtask

  task automatic drain();
    bus.req_valid = '0;
    for (int c = 0; c < 60 && (exp_q.size() > 0 || fl_q.size() > 0); c++) step();
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int issue;
    rst = 1'b1; inj = 1'b0; add_exp = 1'b0; err_exp = 1'b0; ptr_m = 0;
    for (int i = 0; i < N; i++) out_m[i] = 0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sub = '0;
    repeat (3) step();
    chk("add_a_rst", bus.add_a, 0);
    chk("add_b_rst", bus.add_b, 0);
    chk("add_sub_rst", bus.add_sub, 0);
    rst = 1'b0;
    step();

    // Directed 1.0 + 2.0 from requester 0.
    bus.req_valid[0] = 1'b1;
    bus.req_a[0] = 32'h3F800000; bus.req_b[0] = 32'h40000000; bus.req_sub[0] = 1'b0;
    step();
    issue = last_xfer_cyc;
    bus.req_valid = '0;
    chk("dir_add_valid", bus.add_valid, 1);
    chk("dir_add_a", bus.add_a, 32'h3F800000);
    chk("dir_add_b", bus.add_b, 32'h40000000);
    chk("dir_add_sub", bus.add_sub, 0);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    chk("dir_rsp_data", last_rsp_data, 32'h40400000);
    chk("dir_rsp_vec", last_rsp_vec, 4'b0001);
    chk("dir_rsp_lat", last_rsp_cyc - issue, 1 + LAT);

    // All requesters saturating the arbiter.
    run(40, 100, 4'hF);
    drain();
    // Requester 2 alone hits its outstanding limit.
    run(14, 100, 4'b0100);
    drain();
    // Pointer wrap: grant 2 leaves ptr at 3, then 3 and 0 compete.
    bus.req_valid = 4'b0100; new_op(2, 100);
    step();
    chk("wrap_pre", xfer_last, 4'b0100);
    bus.req_valid = '0;
    new_op(3, 100); new_op(0, 100);
    bus.req_valid = 4'b1001;
    step();
    chk("wrap_first", xfer_last, 4'b1000);
    bus.req_valid[3] = 1'b0;
    step();
    chk("wrap_second", xfer_last, 4'b0001);
    drain();
    // Random traffic.
    run(300, 60, 4'hF);
    drain();

    // Stray adder result with nothing in flight.
    inj = 1'b1;
    step();
    inj = 1'b0;
    err_exp = 1'b1;
    repeat (4) step();

    // Reset with ops in flight.
    run(3, 100, 4'hF);
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid[1] = 1'b1; new_op(1, 100); bus.req_valid[1] = 1'b1;
    step();
    chk("post_rst_accept", xfer_last, 4'b0010);
    bus.req_valid = '0;
    drain();
    run(30, 50, 4'hF);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
